// File: rtl/ysyx_22040125_exmem_skid.sv
// EXE->MEM pipeline register with optional two-entry skid buffer.
// SKID_EN=1 keeps in_ready fully registered; SKID_EN=0 is a single entry with combinational ready.
module ysyx_22040125_exmem_skid #(
   parameter int unsigned SKID_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_pc,
   input  logic [63:0] in_result,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic [2:0]  in_mem_op,
   input  logic        in_mem_rd,
   input  logic        in_mem_wr,
   input  logic        in_reg_wr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [63:0] out_result,
   output logic [63:0] out_wdata,
   output logic [4:0]  out_rd,
   output logic [2:0]  out_mem_op,
   output logic        out_mem_rd,
   output logic        out_mem_wr,
   output logic        out_reg_wr,
   output logic [1:0]  occ
);

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] result;
      logic [63:0] wdata;
      logic [4:0]  rd;
      logic [2:0]  mem_op;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } beat_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state;
   beat_t  main_q;
   beat_t  skid_q;
   beat_t  in_beat;
   logic   rdy_q;
   logic   in_xfer;
   logic   out_xfer;

   // Writes to x0 are squashed at capture so MEM/WB never see them.
   assign in_beat = {in_pc, in_result, in_wdata, in_rd, in_mem_op,
                     in_mem_rd, in_mem_wr, in_reg_wr & (in_rd != 5'd0)};

   assign out_valid = (state != EMPTY);
   assign occ       = state;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // rdy_q is low only during reset and while the skid entry is occupied.
   generate
      if (SKID_EN != 0) begin : g_skid
         assign in_ready = rdy_q;
      end else begin : g_single
         assign in_ready = rdy_q & (out_ready | ~out_valid);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b0;
      end else if (flush) begin
         state <= EMPTY;
         rdy_q <= 1'b1;
      end else begin
         rdy_q <= 1'b1;
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  main_q <= in_beat;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_beat;
               end else if (out_xfer) begin
                  state <= EMPTY;
               end else if (in_xfer && (SKID_EN != 0)) begin
                  skid_q <= in_beat;
                  state  <= TWO;
                  rdy_q  <= 1'b0;
               end
            end
            TWO: begin
               rdy_q <= 1'b0;
               if (out_xfer) begin
                  main_q <= skid_q;
                  state  <= ONE;
                  rdy_q  <= 1'b1;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign out_pc     = main_q.pc;
   assign out_result = main_q.result;
   assign out_wdata  = main_q.wdata;
   assign out_rd     = main_q.rd;
   assign out_mem_op = main_q.mem_op;
   assign out_mem_rd = main_q.mem_rd;
   assign out_mem_wr = main_q.mem_wr;
   assign out_reg_wr = main_q.reg_wr;

endmodule

// File: tb/tb_ysyx_22040125_exmem_skid.sv
// Scoreboard bench for the EXE->MEM skid register: the skid instance is checked against a
// queue/occupancy model, and a single-entry instance is exercised with directed checks.
module tb_ysyx_22040125_exmem_skid;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] result;
      logic [63:0] wdata;
      logic [4:0]  rd;
      logic [2:0]  mem_op;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } beat_t;

   logic        clk, rst, flush;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic        in_valid0, in_ready0, o0_valid, out_ready0;
   logic [63:0] in_pc, in_result, in_wdata;
   logic [4:0]  in_rd;
   logic [2:0]  in_mem_op;
   logic        in_mem_rd, in_mem_wr, in_reg_wr;
   logic [63:0] out_pc, out_result, out_wdata, o0_pc, o0_result, o0_wdata;
   logic [4:0]  out_rd, o0_rd;
   logic [2:0]  out_mem_op, o0_mem_op;
   logic        out_mem_rd, out_mem_wr, out_reg_wr, o0_mem_rd, o0_mem_wr, o0_reg_wr;
   logic [1:0]  occ, o0_occ;

   ysyx_22040125_exmem_skid #(.SKID_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_result(in_result), .in_wdata(in_wdata), .in_rd(in_rd),
      .in_mem_op(in_mem_op), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
      .in_reg_wr(in_reg_wr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_result(out_result), .out_wdata(out_wdata), .out_rd(out_rd),
      .out_mem_op(out_mem_op), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_reg_wr(out_reg_wr), .occ(occ)
   );

   ysyx_22040125_exmem_skid #(.SKID_EN(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_pc(in_pc), .in_result(in_result), .in_wdata(in_wdata), .in_rd(in_rd),
      .in_mem_op(in_mem_op), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
      .in_reg_wr(in_reg_wr), .flush(flush), .out_valid(o0_valid), .out_ready(out_ready0),
      .out_pc(o0_pc), .out_result(o0_result), .out_wdata(o0_wdata), .out_rd(o0_rd),
      .out_mem_op(o0_mem_op), .out_mem_rd(o0_mem_rd), .out_mem_wr(o0_mem_wr),
      .out_reg_wr(o0_reg_wr), .occ(o0_occ)
   );

   beat_t q[$];
   int    model_occ;
   bit    armed;
   int    tests, fails;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic beat_t cur_beat();
      return {in_pc, in_result, in_wdata, in_rd, in_mem_op, in_mem_rd, in_mem_wr,
              in_reg_wr && (in_rd != 5'd0)};
   endfunction

   // Monitor: occupancy/handshake model checks and in-order payload compare.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("occ", 64'(occ), 64'(model_occ));
         check("out_valid", 64'(out_valid), 64'(model_occ != 0));
         check("in_ready", 64'(in_ready), 64'(armed && model_occ < 2));
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got pc 0x%0h, expected no beat", out_pc);
            end else begin
               beat_t e;
               e = q[0];
               check("out_pc", out_pc, e.pc);
               check("out_result", out_result, e.result);
               check("out_wdata", out_wdata, e.wdata);
               check("out_ctrl", 64'({out_rd, out_mem_op, out_mem_rd, out_mem_wr, out_reg_wr}),
                     64'({e.rd, e.mem_op, e.mem_rd, e.mem_wr, e.reg_wr}));
               if (out_ready === 1'b1) void'(q.pop_front());
            end
         end
      end
   end

   // One clock: update the abstract model from the inputs presented at this edge.
   task automatic step();
      bit acc, outx;
      @(posedge clk);
      if (rst) begin
         acc  = in_valid && armed && model_occ < 2;
         outx = out_ready && model_occ > 0;
         if (flush) begin
            q.delete();
            model_occ = 0;
         end else begin
            if (acc) q.push_back(cur_beat());
            model_occ = model_occ + int'(acc) - int'(outx);
         end
         armed = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_occ", 64'(occ), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst0_out_valid", 64'(o0_valid), 64'd0);
      q.delete();
      model_occ = 0;
      armed = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic set_beat(input logic [63:0] pc, input logic [4:0] rd, input logic reg_wr);
      in_pc = pc;
      in_result = {$urandom, $urandom};
      in_wdata = {$urandom, $urandom};
      in_rd = rd;
      in_mem_op = 3'($urandom);
      in_mem_rd = 1'($urandom);
      in_mem_wr = 1'($urandom);
      in_reg_wr = reg_wr;
   endtask

   initial begin
      tests = 0; fails = 0; model_occ = 0; armed = 1'b0;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_valid0 = 1'b0; out_ready0 = 1'b0;
      set_beat(64'd0, 5'd0, 1'b0);
      #2;
      do_reset();
      step();

      // Streaming
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         set_beat(64'h8000_0000 + 64'(4 * i), 5'(i + 1), 1'b1);
         step();
      end
      in_valid = 1'b0;
      step(); step();

      // Backpressure through the skid entry
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_beat(64'h100, 5'd1, 1'b1); step();
      set_beat(64'h104, 5'd2, 1'b1); step();
      set_beat(64'h108, 5'd3, 1'b1); step(); step();
      check("bp_occ", 64'(occ), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      step(); step();
      in_valid = 1'b0;
      step(); step();

      // Flush with simultaneous accept
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_beat(64'h110, 5'd4, 1'b1); step();
      set_beat(64'h114, 5'd4, 1'b1); step();
      set_beat(64'h200, 5'd4, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_occ", 64'(occ), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      step(); step();

      // x0 writeback squash
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_beat(64'h400, 5'd0, 1'b1); step();
      in_valid = 1'b0;
      check("x0_reg_wr", 64'(out_reg_wr), 64'd0);
      out_ready = 1'b1; step();
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(64'h404, 5'd5, 1'b1); step();
      in_valid = 1'b0;
      check("x5_reg_wr", 64'(out_reg_wr), 64'd1);
      out_ready = 1'b1; step(); step();

      // Reset while holding two beats
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_beat(64'h500, 5'd6, 1'b1); step();
      set_beat(64'h504, 5'd7, 1'b1); step();
      in_valid = 1'b0;
      check("pre_rst_occ", 64'(occ), 64'd2);
      do_reset();
      step(); step();

      // Single-entry variant: combinational ready
      in_valid0 = 1'b1; out_ready0 = 1'b0;
      set_beat(64'h300, 5'd5, 1'b1); step();
      check("s0_out_valid", 64'(o0_valid), 64'd1);
      check("s0_out_pc", o0_pc, 64'h300);
      check("s0_reg_wr", 64'(o0_reg_wr), 64'd1);
      check("s0_in_ready_low", 64'(in_ready0), 64'd0);
      out_ready0 = 1'b1;
      #1;
      check("s0_in_ready_comb", 64'(in_ready0), 64'd1);
      set_beat(64'h304, 5'd0, 1'b1); step();
      check("s0_out_pc2", o0_pc, 64'h304);
      check("s0_x0_reg_wr", 64'(o0_reg_wr), 64'd0);
      in_valid0 = 1'b0; step();
      check("s0_drained", 64'(o0_valid), 64'd0);
      out_ready0 = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 19) == 0);
         set_beat({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom));
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      check("drain_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ysyx_22040125_exmem_skid.md
YSYX_22040125_EXMEM_SKID -- requirements
Module: ysyx_22040125_exmem_skid

Interface
REQ-001 Parameter: SKID_EN, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single entry with in_ready = out_ready | ~out_valid.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  EXE stage presents a beat.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 in_pc  input  64  instruction PC.
REQ-007 in_result  input  64  ALU result / memory address.
REQ-008 in_wdata  input  64  store data.
REQ-009 in_rd  input  5  destination register index.
REQ-010 in_mem_op  input  3  funct3 load/store size and sign.
REQ-011 in_mem_rd, in_mem_wr, in_reg_wr  input  1 each  load, store and writeback enables.
REQ-012 flush  input  1  synchronous kill of all held beats.
REQ-013 out_valid  output  1  MEM stage beat valid.
REQ-014 out_ready  input  1  MEM stage accepts the beat.
REQ-015 out_pc, out_result, out_wdata, out_rd, out_mem_op, out_mem_rd, out_mem_wr, out_reg_wr  output  widths as REQ-006..REQ-011  held beat fields.
REQ-016 occ  output  2  number of held beats, 0..2.

Function
REQ-017 Transfer in: in_valid & in_ready at a clock edge; transfer out: out_valid & out_ready at a clock edge.
REQ-018 Storage: main entry (drives out_*) and, if SKID_EN=1, one skid entry.
REQ-019 States: EMPTY (occ=0), ONE (main valid), TWO (main and skid valid; SKID_EN=1 only).
REQ-020 EMPTY: in transfer -> ONE, beat in main.
REQ-021 ONE: in only -> TWO (SKID_EN=1), beat in skid; out only -> EMPTY; in and out together -> ONE, new beat in main.
REQ-022 TWO: out transfer -> ONE, skid moves to main the same edge; no in transfer is possible.
REQ-023 SKID_EN=1: in_ready is a register equal to ~skid_valid, with no combinational path from out_ready.
REQ-024 SKID_EN=0: in_ready = out_ready | ~out_valid, combinationally.
REQ-025 out_valid = main valid, registered, with no combinational path from in_valid.
REQ-026 Latency: a beat accepted at edge N appears on out_* after edge N when the block is EMPTY, or after edge N and once the preceding beat transfers out.
REQ-027 Ordering: beats leave in acceptance order; none duplicated or lost except by flush.
REQ-028 Capture rule: out_reg_wr stored as in_reg_wr & (in_rd != 0); all other fields stored verbatim.
REQ-029 out_* hold stable while out_valid=1 and out_ready=0.
REQ-030 flush=1 at an edge: main and skid valids cleared; occ=0; in_ready=1 next cycle.
REQ-031 flush has priority over a simultaneous in transfer: the incoming beat is dropped.
REQ-032 A simultaneous out transfer and flush counts as completed for the consumer; the block takes no further action.
REQ-033 Payload fields of invalid entries are don't-care except after reset (REQ-034).

Reset
REQ-034 rst=0 asynchronously clears valids and all out_* to 0, sets occ=0, and sets in_ready=0 while reset is asserted.
REQ-035 First edge after rst deasserts: in_ready=1.
REQ-036 Reset asserted mid-operation discards held beats; no out transfer occurs until new input arrives.

Verification
REQ-037 Reset with held beats: assert rst with occ=2 -> out_valid=0, out_pc=0 and occ=0 immediately without a clock; in_ready=1 one edge after release.
REQ-038 Streaming: out_ready=1 and 4 beats with pc 0x80000000..0x8000000C back-to-back -> out_pc follows 1 cycle later in order, occ=1 steady, in_ready=1 throughout.
REQ-039 Backpressure (SKID_EN=1): out_ready=0 and beats A=0x100, B=0x104, C=0x108 -> A and B accepted, occ=2, in_ready=0 while C is held; set out_ready=1 -> out_pc A, B, C on consecutive edges.
REQ-040 Flush and accept together: occ=2, flush=1 with in_valid=1 and pc 0x200 -> next cycle occ=0, out_valid=0, beat 0x200 never appears.
REQ-041 x0 writeback: in_rd=0 and in_reg_wr=1 -> out_reg_wr=0; in_rd=5 -> out_reg_wr=1.
REQ-042 SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; raise out_ready -> in_ready=1 combinationally.
